// File: rtl/bus_arbiter_if.sv
// Bus bundle between two requesting masters, the arbiter and a single slave.
// The slave modport is the arbiter's view; the master modport is the surrounding system.
interface bus_arbiter_if #(
    parameter int ADDR_WIDTH = 19,
    parameter int BUS_WIDTH  = 32,
    parameter int ACCW       = 2
);
    // Handshake: mN_req, s_req, s_resp and mN_resp are single-cycle strobes with no
    // backpressure. A request's fields are sampled only in its strobe cycle; a
    // response's data/fault are valid only while its strobe is high.
    logic                  m0_req;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic                  m0_wr_b;
    logic [ACCW-1:0]       m0_acc;
    logic [BUS_WIDTH-1:0]  m0_wdata;
    logic                  m0_resp;
    logic [BUS_WIDTH-1:0]  m0_rdata;
    logic                  m0_fault;

    logic                  m1_req;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic                  m1_wr_b;
    logic [ACCW-1:0]       m1_acc;
    logic [BUS_WIDTH-1:0]  m1_wdata;
    logic                  m1_resp;
    logic [BUS_WIDTH-1:0]  m1_rdata;
    logic                  m1_fault;

    logic                  s_req;
    logic [ADDR_WIDTH-1:0] s_addr;
    logic                  s_wr_b;
    logic [ACCW-1:0]       s_acc;
    logic [BUS_WIDTH-1:0]  s_wdata;
    logic                  s_resp;
    logic [BUS_WIDTH-1:0]  s_rdata;
    logic                  s_fault;

    logic [1:0]            ovr;

    modport slave (
        input  m0_req, m0_addr, m0_wr_b, m0_acc, m0_wdata,
        output m0_resp, m0_rdata, m0_fault,
        input  m1_req, m1_addr, m1_wr_b, m1_acc, m1_wdata,
        output m1_resp, m1_rdata, m1_fault,
        output s_req, s_addr, s_wr_b, s_acc, s_wdata,
        input  s_resp, s_rdata, s_fault,
        output ovr
    );

    modport master (
        output m0_req, m0_addr, m0_wr_b, m0_acc, m0_wdata,
        input  m0_resp, m0_rdata, m0_fault,
        output m1_req, m1_addr, m1_wr_b, m1_acc, m1_wdata,
        input  m1_resp, m1_rdata, m1_fault,
        input  s_req, s_addr, s_wr_b, s_acc, s_wdata,
        output s_resp, s_rdata, s_fault,
        input  ovr
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter onto one slave: one buffered request per master,
// one transaction in flight, response routing and a slave response timeout.
module bus_arbiter #(
    parameter int ADDR_WIDTH = 19,
    parameter int TIMEOUT    = 255,
    parameter int BUS_WIDTH  = 32,
    parameter int ACC_CNT    = 4
) (
    input  logic         clk,
    input  logic         rstn,
    bus_arbiter_if.slave bus,
    output logic         dbg_state,
    output logic         dbg_owner
);
    localparam int ACCW = (ACC_CNT > 1) ? $clog2(ACC_CNT) : 1;
    localparam logic [7:0] TMO = 8'(TIMEOUT);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

    state_e                state_q, state_d;

    logic [1:0]            req;
    logic [ADDR_WIDTH-1:0] in_addr [2];
    logic [1:0]            in_wr_b;
    logic [ACCW-1:0]       in_acc  [2];
    logic [BUS_WIDTH-1:0]  in_wdata[2];

    logic [1:0]            out_q, out_d;
    logic [1:0]            ovr_q, ovr_d;
    logic [ADDR_WIDTH-1:0] buf_addr_q [2], buf_addr_d [2];
    logic [1:0]            buf_wr_b_q, buf_wr_b_d;
    logic [ACCW-1:0]       buf_acc_q  [2], buf_acc_d  [2];
    logic [BUS_WIDTH-1:0]  buf_wdata_q[2], buf_wdata_d[2];

    logic [1:0]            resp_q, resp_d;
    logic [1:0]            fault_q, fault_d;
    logic [BUS_WIDTH-1:0]  rdata_q[2], rdata_d[2];

    logic                  s_req_q, s_req_d;
    logic [ADDR_WIDTH-1:0] s_addr_q, s_addr_d;
    logic                  s_wr_b_q, s_wr_b_d;
    logic [ACCW-1:0]       s_acc_q, s_acc_d;
    logic [BUS_WIDTH-1:0]  s_wdata_q, s_wdata_d;

    logic                  last_q, last_d;
    logic                  owner_q, owner_d;
    logic                  flt_q, flt_d;
    logic [7:0]            cnt_q, cnt_d;

    logic                  done;
    logic                  done_flt;
    logic [BUS_WIDTH-1:0]  done_rdata;
    logic [1:0]            cand;
    logic                  grant;
    logic                  winner;
    logic                  bypass;

    assign req         = {bus.m1_req, bus.m0_req};
    assign in_addr[0]  = bus.m0_addr;
    assign in_addr[1]  = bus.m1_addr;
    assign in_wr_b     = {bus.m1_wr_b, bus.m0_wr_b};
    assign in_acc[0]   = bus.m0_acc;
    assign in_acc[1]   = bus.m1_acc;
    assign in_wdata[0] = bus.m0_wdata;
    assign in_wdata[1] = bus.m1_wdata;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // A completing transaction re-arbitrates in the same cycle, excluding its own
    // owner, so the next grant can go out alongside the response.
    always_comb begin
        done       = 1'b0;
        done_flt   = 1'b0;
        done_rdata = '0;
        if (state_q == S_WAIT) begin
            if (bus.s_resp) begin
                done       = 1'b1;
                done_rdata = bus.s_rdata;
                done_flt   = s_req_q ? bus.s_fault : flt_q;
            end else if (cnt_q == TMO) begin
                done     = 1'b1;
                done_flt = 1'b1;
            end
        end
        cand    = (out_q | req) & ~(done ? {owner_q, ~owner_q} : 2'b00);
        grant   = ((state_q == S_IDLE) || done) && (cand != 2'b00);
        winner  = (cand == 2'b11) ? ~last_q : cand[1];
        bypass  = req[winner] && !out_q[winner];
        state_d = state_q;
        if (grant)     state_d = S_WAIT;
        else if (done) state_d = S_IDLE;
    end

    always_comb begin
        out_d       = out_q;
        ovr_d       = ovr_q;
        buf_addr_d  = buf_addr_q;
        buf_wr_b_d  = buf_wr_b_q;
        buf_acc_d   = buf_acc_q;
        buf_wdata_d = buf_wdata_q;
        resp_d      = 2'b00;
        fault_d     = fault_q;
        rdata_d     = rdata_q;
        s_req_d     = grant;
        s_addr_d    = s_addr_q;
        s_wr_b_d    = s_wr_b_q;
        s_acc_d     = s_acc_q;
        s_wdata_d   = s_wdata_q;
        last_d      = last_q;
        owner_d     = owner_q;
        flt_d       = flt_q;
        cnt_d       = cnt_q;

        for (int n = 0; n < 2; n++) begin
            if (req[n]) begin
                if (out_q[n]) begin
                    ovr_d[n] = 1'b1;
                end else begin
                    out_d[n]       = 1'b1;
                    buf_addr_d[n]  = in_addr[n];
                    buf_wr_b_d[n]  = in_wr_b[n];
                    buf_acc_d[n]   = in_acc[n];
                    buf_wdata_d[n] = in_wdata[n];
                end
            end
        end

        if (s_req_q) flt_d = bus.s_fault;
        if ((state_q == S_WAIT) && !done) cnt_d = cnt_q + 8'd1;

        if (done) begin
            out_d[owner_q]   = 1'b0;
            resp_d[owner_q]  = 1'b1;
            rdata_d[owner_q] = done_rdata;
            fault_d[owner_q] = done_flt;
        end

        if (grant) begin
            owner_d = winner;
            last_d  = winner;
            cnt_d   = '0;
            if (bypass) begin
                s_addr_d  = in_addr[winner];
                s_wr_b_d  = in_wr_b[winner];
                s_acc_d   = in_acc[winner];
                s_wdata_d = in_wdata[winner];
            end else begin
                s_addr_d  = buf_addr_q[winner];
                s_wr_b_d  = buf_wr_b_q[winner];
                s_acc_d   = buf_acc_q[winner];
                s_wdata_d = buf_wdata_q[winner];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q       <= 2'b00;
            ovr_q       <= 2'b00;
            buf_addr_q  <= '{default: '0};
            buf_wr_b_q  <= 2'b00;
            buf_acc_q   <= '{default: '0};
            buf_wdata_q <= '{default: '0};
            resp_q      <= 2'b00;
            fault_q     <= 2'b00;
            rdata_q     <= '{default: '0};
            s_req_q     <= 1'b0;
            s_addr_q    <= '0;
            s_wr_b_q    <= 1'b0;
            s_acc_q     <= '0;
            s_wdata_q   <= '0;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            flt_q       <= 1'b0;
            cnt_q       <= 8'd0;
        end else begin
            out_q       <= out_d;
            ovr_q       <= ovr_d;
            buf_addr_q  <= buf_addr_d;
            buf_wr_b_q  <= buf_wr_b_d;
            buf_acc_q   <= buf_acc_d;
            buf_wdata_q <= buf_wdata_d;
            resp_q      <= resp_d;
            fault_q     <= fault_d;
            rdata_q     <= rdata_d;
            s_req_q     <= s_req_d;
            s_addr_q    <= s_addr_d;
            s_wr_b_q    <= s_wr_b_d;
            s_acc_q     <= s_acc_d;
            s_wdata_q   <= s_wdata_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            flt_q       <= flt_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.m0_resp  = resp_q[0];
    assign bus.m0_rdata = rdata_q[0];
    assign bus.m0_fault = fault_q[0];
    assign bus.m1_resp  = resp_q[1];
    assign bus.m1_rdata = rdata_q[1];
    assign bus.m1_fault = fault_q[1];
    assign bus.s_req    = s_req_q;
    assign bus.s_addr   = s_addr_q;
    assign bus.s_wr_b   = s_wr_b_q;
    assign bus.s_acc    = s_acc_q;
    assign bus.s_wdata  = s_wdata_q;
    assign bus.ovr      = ovr_q;
    assign dbg_state    = state_q;
    assign dbg_owner    = owner_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a per-cycle vector table of inputs and the
// registered outputs expected one edge later, plus a hand-written mid-WAIT reset.
module tb_bus_arbiter;
    localparam int AW   = 19;
    localparam int BW   = 32;
    localparam int ACCW = 2;
    localparam int TMO  = 4;
    localparam int SPLIT = 49;

    logic clk = 1'b0;
    logic rstn;
    logic dbg_state;
    logic dbg_owner;

    always #5 clk = ~clk;

    bus_arbiter_if #(.ADDR_WIDTH(AW), .BUS_WIDTH(BW), .ACCW(ACCW)) bus ();

    bus_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT(TMO), .BUS_WIDTH(BW), .ACC_CNT(4)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus),
        .dbg_state(dbg_state),
        .dbg_owner(dbg_owner)
    );

    typedef struct {
        logic [1:0]    req;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic          wr;
        logic          sr;
        logic [BW-1:0] rd;
        logic          sf;
        logic          es;
        logic          eo;
        logic [AW-1:0] ea;
        logic          ew;
        logic [1:0]    eresp;
        logic [BW-1:0] erd;
        logic          ef;
        logic [1:0]    eovr;
    } vec_t;

    vec_t tv[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t v(input int req, input int a0, input int a1, input int wr,
                               input int sr, input int rd, input int sf,
                               input int es, input int eo, input int ea, input int ew,
                               input int eresp, input int erd, input int ef, input int eovr);
        vec_t t;
        t.req = 2'(req);  t.a0 = AW'(a0);  t.a1 = AW'(a1);  t.wr = 1'(wr);
        t.sr = 1'(sr);    t.rd = BW'(rd);  t.sf = 1'(sf);
        t.es = 1'(es);    t.eo = 1'(eo);   t.ea = AW'(ea);  t.ew = 1'(ew);
        t.eresp = 2'(eresp); t.erd = BW'(erd); t.ef = 1'(ef); t.eovr = 2'(eovr);
        return t;
    endfunction

    function automatic vec_t nop(input int eovr);
        return v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, eovr);
    endfunction

    function automatic logic [BW-1:0] wd(input logic m, input logic [AW-1:0] a);
        return {(m ? 13'h1B1 : 13'h0A5), a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        bus.m0_req   = t.req[0];
        bus.m0_addr  = t.req[0] ? t.a0 : AW'($urandom);
        bus.m0_wr_b  = t.req[0] ? t.wr : 1'($urandom);
        bus.m0_acc   = t.req[0] ? 2'd2 : 2'd3;
        bus.m0_wdata = t.req[0] ? wd(1'b0, t.a0) : $urandom;
        bus.m1_req   = t.req[1];
        bus.m1_addr  = t.req[1] ? t.a1 : AW'($urandom);
        bus.m1_wr_b  = t.req[1] ? t.wr : 1'($urandom);
        bus.m1_acc   = t.req[1] ? 2'd1 : 2'd3;
        bus.m1_wdata = t.req[1] ? wd(1'b1, t.a1) : $urandom;
        bus.s_resp   = t.sr;
        bus.s_rdata  = t.sr ? t.rd : $urandom;
        bus.s_fault  = t.sf;
    endtask

    task automatic check_vec(input int k, input vec_t t);
        string p;
        p = $sformatf("v%0d", k);
        chk({p, ".s_req"},   32'(bus.s_req),   32'(t.es));
        chk({p, ".m0_resp"}, 32'(bus.m0_resp), 32'(t.eresp[0]));
        chk({p, ".m1_resp"}, 32'(bus.m1_resp), 32'(t.eresp[1]));
        chk({p, ".ovr"},     32'(bus.ovr),     32'(t.eovr));
        if (t.es) begin
            chk({p, ".s_addr"},  32'(bus.s_addr),  32'(t.ea));
            chk({p, ".s_wr_b"},  32'(bus.s_wr_b),  32'(t.ew));
            chk({p, ".s_acc"},   32'(bus.s_acc),   t.eo ? 32'd1 : 32'd2);
            chk({p, ".s_wdata"}, bus.s_wdata,      wd(t.eo, t.ea));
        end
        if (t.eresp[0]) begin
            chk({p, ".m0_rdata"}, bus.m0_rdata,       t.erd);
            chk({p, ".m0_fault"}, 32'(bus.m0_fault), 32'(t.ef));
        end
        if (t.eresp[1]) begin
            chk({p, ".m1_rdata"}, bus.m1_rdata,       t.erd);
            chk({p, ".m1_fault"}, 32'(bus.m1_fault), 32'(t.ef));
        end
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int k = lo; k < hi; k++) begin
            drive(tv[k]);
            @(negedge clk);
            check_vec(k, tv[k]);
        end
    endtask

    task automatic check_all_zero(input string p);
        chk({p, ".s_req"},    32'(bus.s_req),    0);
        chk({p, ".s_addr"},   32'(bus.s_addr),   0);
        chk({p, ".s_wr_b"},   32'(bus.s_wr_b),   0);
        chk({p, ".s_acc"},    32'(bus.s_acc),    0);
        chk({p, ".s_wdata"},  bus.s_wdata,       0);
        chk({p, ".m0_resp"},  32'(bus.m0_resp),  0);
        chk({p, ".m1_resp"},  32'(bus.m1_resp),  0);
        chk({p, ".m0_rdata"}, bus.m0_rdata,      0);
        chk({p, ".m1_rdata"}, bus.m1_rdata,      0);
        chk({p, ".m0_fault"}, 32'(bus.m0_fault), 0);
        chk({p, ".m1_fault"}, 32'(bus.m1_fault), 0);
        chk({p, ".ovr"},      32'(bus.ovr),      0);
        chk({p, ".state"},    32'(dbg_state),    0);
        chk({p, ".owner"},    32'(dbg_owner),    0);
    endtask

    initial begin
        // single read, m0
        tv.push_back(v(1, 'h10, 0, 0,  0, 0, 0,  1, 0, 'h10, 0,  0, 0, 0,  0));
        tv.push_back(nop(0));
        tv.push_back(v(0, 0, 0, 0,  1, 'hDEADBEEF, 0,  0, 0, 0, 0,  1, 'hDEADBEEF, 0,  0));
        tv.push_back(nop(0));
        // contention after m0 was last: m1 first, m0 from its buffer
        tv.push_back(v(3, 'h30, 'h40, 0,  0, 0, 0,  1, 1, 'h40, 0,  0, 0, 0,  0));
        tv.push_back(nop(0));
        tv.push_back(v(0, 0, 0, 0,  1, 'h11111111, 0,  1, 0, 'h30, 0,  2, 'h11111111, 0,  0));
        tv.push_back(nop(0));
        tv.push_back(v(0, 0, 0, 0,  1, 'h22222222, 0,  0, 0, 0, 0,  1, 'h22222222, 0,  0));
        tv.push_back(nop(0));
        // m1 write, fault in the s_req cycle
        tv.push_back(v(2, 0, 'h50, 1,  0, 0, 0,  1, 1, 'h50, 1,  0, 0, 0,  0));
        tv.push_back(v(0, 0, 0, 0,  0, 0, 1,  0, 0, 0, 0,  0, 0, 0,  0));
        tv.push_back(v(0, 0, 0, 0,  1, 'h13, 0,  0, 0, 0, 0,  2, 'h13, 1,  0));
        tv.push_back(nop(0));
        // contention after m1 was last: m0 first
        tv.push_back(v(3, 'h60, 'h70, 0,  0, 0, 0,  1, 0, 'h60, 0,  0, 0, 0,  0));
        tv.push_back(nop(0));
        tv.push_back(v(0, 0, 0, 0,  1, 'hAAAA5555, 0,  1, 1, 'h70, 0,  1, 'hAAAA5555, 0,  0));
        tv.push_back(nop(0));
        tv.push_back(v(0, 0, 0, 0,  1, 'h5555AAAA, 0,  0, 0, 0, 0,  2, 'h5555AAAA, 0,  0));
        tv.push_back(nop(0));
        // overrun on m0: second request dropped
        tv.push_back(v(1, 'h10, 0, 0,  0, 0, 0,  1, 0, 'h10, 0,  0, 0, 0,  0));
        tv.push_back(v(1, 'h20, 0, 0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  1));
        tv.push_back(v(0, 0, 0, 0,  1, 'h12345678, 0,  0, 0, 0, 0,  1, 'h12345678, 0,  1));
        tv.push_back(nop(1));
        tv.push_back(nop(1));
        // m1 re-requests in its own response cycle
        tv.push_back(v(2, 0, 'h80, 0,  0, 0, 0,  1, 1, 'h80, 0,  0, 0, 0,  1));
        tv.push_back(nop(1));
        tv.push_back(v(0, 0, 0, 0,  1, 'h0BADF00D, 0,  0, 0, 0, 0,  2, 'h0BADF00D, 0,  1));
        tv.push_back(v(2, 0, 'h84, 0,  0, 0, 0,  1, 1, 'h84, 0,  0, 0, 0,  1));
        tv.push_back(nop(1));
        tv.push_back(v(0, 0, 0, 0,  1, 'h600D, 0,  0, 0, 0, 0,  2, 'h600D, 0,  1));
        tv.push_back(nop(1));
        // stray s_resp while idle
        tv.push_back(v(0, 0, 0, 0,  1, 'hFFFFFFFF, 0,  0, 0, 0, 0,  0, 0, 0,  1));
        tv.push_back(nop(1));
        // timeout: response 5 cycles after s_req, late s_resp ignored
        tv.push_back(v(1, 'h90, 0, 0,  0, 0, 0,  1, 0, 'h90, 0,  0, 0, 0,  1));
        for (int i = 0; i < 4; i++) tv.push_back(nop(1));
        tv.push_back(v(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  1, 0, 1,  1));
        tv.push_back(v(0, 0, 0, 0,  1, 'h77, 0,  0, 0, 0, 0,  0, 0, 0,  1));
        tv.push_back(nop(1));
        // s_resp in the same cycle the counter reaches TIMEOUT: normal completion
        tv.push_back(v(2, 0, 'hA0, 0,  0, 0, 0,  1, 1, 'hA0, 0,  0, 0, 0,  1));
        for (int i = 0; i < 4; i++) tv.push_back(nop(1));
        tv.push_back(v(0, 0, 0, 0,  1, 'hCAFE, 0,  0, 0, 0, 0,  2, 'hCAFE, 0,  1));
        tv.push_back(nop(1));
        // after mid-WAIT reset: stray response ignored, last back to 1 so m0 wins
        tv.push_back(v(0, 0, 0, 0,  1, 'h99, 0,  0, 0, 0, 0,  0, 0, 0,  0));
        tv.push_back(v(3, 'h300, 'h304, 0,  0, 0, 0,  1, 0, 'h300, 0,  0, 0, 0,  0));
        tv.push_back(nop(0));
        tv.push_back(v(0, 0, 0, 0,  1, 'h31, 0,  1, 1, 'h304, 0,  1, 'h31, 0,  0));
        tv.push_back(nop(0));
        tv.push_back(v(0, 0, 0, 0,  1, 'h32, 0,  0, 0, 0, 0,  2, 'h32, 0,  0));
        tv.push_back(nop(0));

        rstn = 1'b0;
        drive(nop(0));
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rstn = 1'b1;

        run_rows(0, SPLIT);

        drive(v(1, 'h100, 0, 0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0));
        @(negedge clk);
        chk("rst_wait.s_req", 32'(bus.s_req), 1);
        chk("rst_wait.state", 32'(dbg_state), 1);
        drive(nop(0));
        #2 rstn = 1'b0;
        #1 check_all_zero("rst_wait");
        @(negedge clk);
        chk("rst_wait.hold_m0_resp", 32'(bus.m0_resp), 0);
        rstn = 1'b1;

        run_rows(SPLIT, tv.size());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
